snake_move: RTL

SNAKE_MOVE -- requirements
Module: snake_move

---
 rtl/snake_move_if.sv | 31 +++
 rtl/snake_move.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/snake_move_if.sv
// Bus between the snake movement block and the game logic: control inputs and
// the snake's head, body and status outputs.
interface snake_move_if;
  localparam int unsigned BTN_W  = 4;
  localparam int unsigned SEG_W  = 40;
  localparam int unsigned BODY_W = 200;
  localparam int unsigned LEN_W  = 3;

  logic              start;
  logic              tick;
  logic [BTN_W-1:0]  dir_btn;
  logic              grow;
  logic              isOver;
  logic [SEG_W-1:0]  head;
  logic [BODY_W-1:0] body;
  logic [LEN_W-1:0]  length;
  logic              update;
  logic              running;

  // Game-side view: drives controls, observes the snake.
  modport master (
    output start, tick, dir_btn, grow, isOver,
    input  head, body, length, update, running
  );

  // Snake-side view.
  modport slave (
    input  start, tick, dir_btn, grow, isOver,
    output head, body, length, update, running
  );
endinterface

// File: rtl/snake_move.sv
// Snake movement engine: holds the head position and up to five trailing body
// segments, steps 16 px per tick in the latched direction, grows on food.
module snake_move (
  input  logic        clk,
  input  logic        rst_n,
  snake_move_if.slave bus
);
  localparam int unsigned CW    = 10;
  localparam int unsigned SEG_W = 40;
  localparam int unsigned NSEG  = 5;
  localparam int unsigned LW    = 3;
  localparam int unsigned PAD_W = SEG_W - 2 * CW;

  localparam logic [CW-1:0]    STEP        = CW'(16);
  localparam logic [CW-1:0]    X_MAX       = CW'(608);
  localparam logic [CW-1:0]    Y_MAX       = CW'(448);
  localparam logic [CW-1:0]    X_INIT      = CW'(304);
  localparam logic [CW-1:0]    Y_INIT      = CW'(224);
  localparam logic [CW-1:0]    SEG0_X_INIT = CW'(288);
  localparam logic [SEG_W-1:0] SEG_NONE    = '1;
  localparam logic [LW-1:0]    LEN_INIT    = LW'(1);
  localparam logic [LW-1:0]    LEN_MAX     = LW'(NSEG);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_e;
  // Encoding pairs opposites so that bit 0 flip gives the reverse direction.
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  // Element NSEG-1 is seg0 (nearest the head), element 0 is seg4.
  typedef logic [NSEG-1:0][SEG_W-1:0] body_t;

  localparam body_t BODY_INIT = {PAD_W'(0), SEG0_X_INIT, Y_INIT, {(NSEG-1){SEG_NONE}}};

  state_e            state_q, state_d;
  dir_e              cur_dir_q, cur_dir_d;
  dir_e              next_dir_q, next_dir_d;
  logic [CW-1:0]     hx_q, hx_d;
  logic [CW-1:0]     hy_q, hy_d;
  body_t             body_q, body_d;
  logic [LW-1:0]     length_q, length_d;
  logic              grow_pend_q, grow_pend_d;
  logic              update_q, update_d;
  logic              running_q, running_d;

  dir_e              btn_dir_c;
  logic              btn_any_c;

  // Highest-priority pressed button: up > down > left > right.
  always_comb begin
    btn_any_c = |bus.dir_btn;
    btn_dir_c = DIR_RIGHT;
    if (bus.dir_btn[3])      btn_dir_c = DIR_UP;
    else if (bus.dir_btn[2]) btn_dir_c = DIR_DOWN;
    else if (bus.dir_btn[1]) btn_dir_c = DIR_LEFT;
  end

  // Next-state: game FSM, direction latch, move/grow and output pulses.
  always_comb begin
    state_d     = state_q;
    cur_dir_d   = cur_dir_q;
    next_dir_d  = next_dir_q;
    hx_d        = hx_q;
    hy_d        = hy_q;
    body_d      = body_q;
    length_d    = length_q;
    grow_pend_d = grow_pend_q;
    update_d    = 1'b0;

    if (btn_any_c && (btn_dir_c != dir_e'(cur_dir_q ^ 2'b01))) begin
      next_dir_d = btn_dir_c;
    end

    unique case (state_q)
      IDLE, DEAD: begin
        if (bus.start) begin
          state_d     = RUN;
          cur_dir_d   = DIR_RIGHT;
          next_dir_d  = DIR_RIGHT;
          hx_d        = X_INIT;
          hy_d        = Y_INIT;
          body_d      = BODY_INIT;
          length_d    = LEN_INIT;
          grow_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.isOver) begin
          state_d = DEAD;
        end else if (bus.tick) begin
          cur_dir_d = next_dir_q;
          unique case (next_dir_q)
            DIR_UP:    hy_d = (hy_q < STEP) ? '0 : hy_q - STEP;
            DIR_DOWN:  hy_d = (hy_q > Y_MAX - STEP) ? Y_MAX : hy_q + STEP;
            DIR_LEFT:  hx_d = (hx_q < STEP) ? '0 : hx_q - STEP;
            DIR_RIGHT: hx_d = (hx_q > X_MAX - STEP) ? X_MAX : hx_q + STEP;
            default:   hx_d = hx_q;
          endcase
          if ((grow_pend_q || bus.grow) && (length_q < LEN_MAX)) begin
            length_d = length_q + LW'(1);
          end
          body_d = {PAD_W'(0), hx_q, hy_q, body_q[NSEG-1:1]};
          for (int unsigned j = 0; j < NSEG; j++) begin
            if (LW'(NSEG - 1 - j) >= length_d) begin
              body_d[j] = SEG_NONE;
            end
          end
          grow_pend_d = 1'b0;
          update_d    = 1'b1;
        end else if (bus.grow) begin
          grow_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
  end

  // State and output registers; reset loads the initial snake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_dir_q   <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      hx_q        <= X_INIT;
      hy_q        <= Y_INIT;
      body_q      <= BODY_INIT;
      length_q    <= LEN_INIT;
      grow_pend_q <= 1'b0;
      update_q    <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dir_q   <= cur_dir_d;
      next_dir_q  <= next_dir_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      body_q      <= body_d;
      length_q    <= length_d;
      grow_pend_q <= grow_pend_d;
      update_q    <= update_d;
      running_q   <= running_d;
    end
  end

  assign bus.head    = {PAD_W'(0), hx_q, hy_q};
  assign bus.body    = body_q;
  assign bus.length  = length_q;
  assign bus.update  = update_q;
  assign bus.running = running_q;
endmodule
